icache_lookup_responder: RTL and testbench
==========================================

Name: icache_lookup_responder

Overview:
- Responder side of the fetch-to-I$ request interface.
- Accepts one lookup per cycle from the fetch stage: thread id, word PC, valid, replay, tid parity.
- Returns the instruction word plus a hit/miss flag one cycle later.
- Owns a direct-mapped tag/data array, a single-outstanding line refill engine towards memory, and a power-up tag invalidation sweep.
- On refill completion, reports which thread can replay.

Parameters:
- NTHREAD, 64, number of hardware threads; TIDW = log2(NTHREAD).
- NLINES, 256, cache lines; IDXW = log2(NLINES).
- LINEWORDS, 8, 32-bit words per line; OFFW = log2(LINEWORDS).

Ports:
- gclk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- if_valid  in  1  lookup request valid (cycle T)
- if_tid  in  TIDW  requesting thread
- if_tid_parity  in  1  even parity of if_tid
- if_replay  in  1  request is a replay after a miss
- if_vpc  in  30  word address
- if_data  out  32  instruction word, stored order (fetch does endian swap), valid T+1
- if_hit  out  1  T+1: lookup hit
- if_miss  out  1  T+1: valid lookup missed
- if_perr  out  1  T+1: parity error detected
- mem_req_valid  out  1  line read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  30-OFFW  line address
- mem_rsp_valid  in  1  one data beat
- mem_rsp_data  in  32  beat data, word offsets 0..LINEWORDS-1 in order
- refill_done  out  1  one-cycle pulse, line installed
- refill_tid  out  TIDW  thread whose miss was refilled

Behaviour:
- Address split: offset = vpc[OFFW-1:0], index = vpc[OFFW+IDXW-1:OFFW], tag = vpc[29:OFFW+IDXW].
- Tag RAM stores {valid, tag}; data RAM stores NLINES*LINEWORDS words.
- Both RAMs are read synchronously at T; compare happens in T+1.
- T+1 outputs:
  - if_hit = valid_q & tagvalid & tag match & FSM not INIT.
  - if_miss = valid_q & ~if_hit.
  - if_data = RAM word, don't-care on miss.
  - All are 0 when valid_q = 0.
- if_replay does not affect lookup and is treated identically.
- Refill FSM states:
  - INIT: sweeps index 0..NLINES-1, clearing valid, one line per cycle. After NLINES cycles, goes to IDLE. All lookups miss; no capture.
  - IDLE: a T+1 miss is captured as {tid, line address}, then go to REQ.
  - REQ: mem_req_valid = 1, mem_req_addr held stable. On mem_req_ready, invalidate the target line's tag and go to FILL.
  - FILL: each mem_rsp_valid beat writes the data word at beat counter (0..LINEWORDS-1). The counter wraps to 0 after the last beat; the last beat moves to DONE.
  - DONE: write {1, tag}; refill_done = 1 and refill_tid = captured tid for exactly this cycle; then IDLE.
- Misses while FSM != IDLE are reported on if_miss but not captured; the thread re-fetches later.
- A miss to the line currently being filled also misses, because its tag was invalidated at the REQ handshake.
- Simultaneous RAM read and write to the same address: read returns old contents.
  - A lookup registered in the DONE cycle to the refilled index therefore misses.
- mem_rsp_valid outside FILL is ignored.
- Reset values: if_hit = if_miss = if_perr = mem_req_valid = refill_done = 0; refill_tid = 0; mem_req_addr = 0; FSM = INIT, sweep index 0; valid_q = 0.
- rst mid-refill aborts any REQ/FILL and restarts INIT; late response beats are ignored.

Optional Feature:
- Macro: ICACHE_PARITY_EN.
- Defined:
  - Tag entries and data words each carry one even-parity bit, generated on write.
  - In T+1, if_perr = valid_q & (tag parity bad | data parity bad | ^tid_q != tid_parity_q).
  - Any parity error forces if_hit = 0 and if_miss = 1, so the line is refetched.
  - A tid parity error also suppresses miss capture.
- Undefined: no parity storage; if_perr tied 0; if_tid_parity unused.

Test Plan:
1. Init sweep: rst high 2 cycles, then low. Lookups to vpc 0x000 miss for 256 cycles with mem_req_valid = 0. First miss after the sweep raises mem_req_valid 2 cycles after the request.
2. Cold miss: tid 5, vpc 0x123 -> if_miss = 1 at T+1, mem_req_addr = 0x024. Feed beats 0x10000000+i, i = 0..7. -> refill_done pulse with refill_tid = 5. Re-request vpc 0x123 -> if_hit = 1, if_data = 0x10000003.
3. Backpressure: hold mem_req_ready = 0 for 5 cycles -> mem_req_valid = 1 and mem_req_addr = 0x024 stable throughout. Accept on cycle 6 -> FILL.
4. Busy miss: during FILL, tid 7 looks up vpc 0x400 -> if_miss = 1. After DONE, no new mem_req is issued until tid 7 retries.
5. Conflict: fill vpc 0x123, then look up vpc 0x923 (same index, different tag) -> miss and refill. Afterwards vpc 0x123 -> miss.
6. ICACHE_PARITY_EN: line 0x024 resident, lookup with wrong if_tid_parity -> if_perr = 1, if_miss = 1, if_hit = 0, no mem_req.

Source files
------------

// File: rtl/icache_lookup_responder.sv
// Fetch-side I$ responder: direct-mapped tag/data lookup, single-outstanding line refill, power-up tag sweep.
// Optional ICACHE_PARITY_EN adds even parity on tag entries, data words and the request tid.
module icache_lookup_responder #(
  parameter  int NTHREAD   = 64,
  parameter  int NLINES    = 256,
  parameter  int LINEWORDS = 8,
  localparam int TIDW      = $clog2(NTHREAD),
  localparam int IDXW      = $clog2(NLINES),
  localparam int OFFW      = $clog2(LINEWORDS),
  localparam int TAGW      = 30 - OFFW - IDXW,
  localparam int LAW       = 30 - OFFW
) (
  input  logic            gclk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [TIDW-1:0] if_tid,
  input  logic            if_tid_parity,
  input  logic            if_replay,
  input  logic [29:0]     if_vpc,
  output logic [31:0]     if_data,
  output logic            if_hit,
  output logic            if_miss,
  output logic            if_perr,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [LAW-1:0]  mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic            refill_done,
  output logic [TIDW-1:0] refill_tid
);

`ifdef ICACHE_PARITY_EN
  localparam int TRW = TAGW + 2;
  localparam int DRW = 33;
`else
  localparam int TRW = TAGW + 1;
  localparam int DRW = 32;
`endif

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REQ, S_FILL, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        sweep_q, sweep_d;
  logic [OFFW-1:0]        beat_q, beat_d;
  logic [TIDW-1:0]        cap_tid_q, cap_tid_d;
  logic [LAW-1:0]         cap_line_q, cap_line_d;

  logic                   valid_q, rd_init_q;
  logic [TIDW-1:0]        tid_q;
  logic [TAGW-1:0]        ltag_q;
  logic [IDXW-1:0]        lidx_q;
  logic [TRW-1:0]         tag_rd_q;
  logic [DRW-1:0]         data_rd_q;

  logic [TRW-1:0]         tag_ram  [NLINES];
  logic [DRW-1:0]         data_ram [NLINES*LINEWORDS];

  logic                   tag_we, tag_v, data_we;
  logic [IDXW-1:0]        tag_wa;
  logic [TAGW-1:0]        tag_t;
  logic [IDXW+OFFW-1:0]   data_wa;
  logic [TAGW:0]          tag_wbase;
  logic [TRW-1:0]         tag_wd;
  logic [DRW-1:0]         data_wd;
  logic                   tag_ok, perr, tid_pbad;

  assign tag_wbase = {tag_v, tag_t};
`ifdef ICACHE_PARITY_EN
  logic tidpar_q;
  logic unused_in;
  assign unused_in = if_replay;
  assign tag_wd    = {^tag_wbase, tag_wbase};
  assign data_wd   = {^mem_rsp_data, mem_rsp_data};
  assign tid_pbad  = (^tid_q) != tidpar_q;
  assign perr      = valid_q & ((^tag_rd_q) | (^data_rd_q) | tid_pbad);
`else
  logic unused_in;
  assign unused_in = if_replay ^ if_tid_parity;
  assign tag_wd    = tag_wbase;
  assign data_wd   = mem_rsp_data;
  assign tid_pbad  = 1'b0;
  assign perr      = 1'b0;
`endif

  // Synchronous RAMs: a same-cycle write is not visible to the read (old data returned).
  always_ff @(posedge gclk) begin
    if (if_valid) begin
      tag_rd_q  <= tag_ram[if_vpc[OFFW+IDXW-1:OFFW]];
      data_rd_q <= data_ram[if_vpc[OFFW+IDXW-1:0]];
    end
    if (tag_we)  tag_ram[tag_wa]   <= tag_wd;
    if (data_we) data_ram[data_wa] <= data_wd;
  end

  always_ff @(posedge gclk) begin
    tid_q     <= if_tid;
    ltag_q    <= if_vpc[29:OFFW+IDXW];
    lidx_q    <= if_vpc[OFFW+IDXW-1:OFFW];
    // Reads issued during the sweep may see a not-yet-cleared entry.
    rd_init_q <= (state_q == S_INIT);
`ifdef ICACHE_PARITY_EN
    tidpar_q  <= if_tid_parity;
`endif
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      state_q    <= S_INIT;
      sweep_q    <= '0;
      beat_q     <= '0;
      cap_tid_q  <= '0;
      cap_line_q <= '0;
    end else begin
      valid_q    <= if_valid;
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      beat_q     <= beat_d;
      cap_tid_q  <= cap_tid_d;
      cap_line_q <= cap_line_d;
    end
  end

  assign tag_ok  = tag_rd_q[TAGW] && (tag_rd_q[TAGW-1:0] == ltag_q);
  assign if_hit  = valid_q & tag_ok & (state_q != S_INIT) & ~rd_init_q & ~perr;
  assign if_miss = valid_q & ~if_hit;
  assign if_perr = perr;
  assign if_data = valid_q ? data_rd_q[31:0] : 32'h0;
  assign mem_req_addr = cap_line_q;

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    beat_d        = beat_q;
    cap_tid_d     = cap_tid_q;
    cap_line_d    = cap_line_q;
    tag_we        = 1'b0;
    tag_v         = 1'b0;
    tag_wa        = cap_line_q[IDXW-1:0];
    tag_t         = cap_line_q[LAW-1:IDXW];
    data_we       = 1'b0;
    data_wa       = {cap_line_q[IDXW-1:0], beat_q};
    mem_req_valid = 1'b0;
    refill_done   = 1'b0;
    refill_tid    = '0;
    case (state_q)
      S_INIT: begin
        tag_we  = 1'b1;
        tag_wa  = sweep_q;
        sweep_d = sweep_q + IDXW'(1);
        if (sweep_q == IDXW'(NLINES-1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (if_miss && !tid_pbad) begin
          cap_tid_d  = tid_q;
          cap_line_d = {ltag_q, lidx_q};
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          // Drop the victim now so lookups to it miss while the line is half-written.
          tag_we  = 1'b1;
          beat_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_rsp_valid) begin
          data_we = 1'b1;
          beat_d  = beat_q + OFFW'(1);
          if (beat_q == OFFW'(LINEWORDS-1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        tag_we      = 1'b1;
        tag_v       = 1'b1;
        refill_done = 1'b1;
        refill_tid  = cap_tid_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_icache_lookup_responder.sv
// Bench for icache_lookup_responder: vector table, hand corner sequences, random lookups vs a line-level model.
module tb_icache_lookup_responder;
  localparam int TIDW = 6, IDXW = 8, TAGW = 19, LAW = 27, NLINES = 256;

  logic            gclk = 1'b0;
  logic            rst, if_valid, if_tid_parity, if_replay;
  logic [TIDW-1:0] if_tid, refill_tid;
  logic [29:0]     if_vpc;
  logic [31:0]     if_data, mem_rsp_data;
  logic            if_hit, if_miss, if_perr, mem_req_valid, mem_req_ready, mem_rsp_valid, refill_done;
  logic [LAW-1:0]  mem_req_addr;

  always #5 gclk = ~gclk;

  icache_lookup_responder #(.NTHREAD(64), .NLINES(256), .LINEWORDS(8)) dut (
    .gclk(gclk), .rst(rst), .if_valid(if_valid), .if_tid(if_tid), .if_tid_parity(if_tid_parity),
    .if_replay(if_replay), .if_vpc(if_vpc), .if_data(if_data), .if_hit(if_hit), .if_miss(if_miss),
    .if_perr(if_perr), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .refill_done(refill_done), .refill_tid(refill_tid));

  int n_cmp = 0, n_bad = 0;

  // Line-level reference: which tag each index holds and the base value its words were filled from.
  bit              m_vld  [NLINES];
  logic [TAGW-1:0] m_tag  [NLINES];
  logic [31:0]     m_base [NLINES];

  logic        r_hit, r_miss, r_perr;
  logic [31:0] r_data;

  typedef struct {
    logic [TIDW-1:0] tid;
    logic [29:0]     vpc;
    bit              hit;
    logic [31:0]     data;   // expected word on hit, fill base on miss
    int              dly;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk); #1;
  endtask

  task automatic lookup(input logic [TIDW-1:0] tid, input logic [29:0] vpc, input bit bad_par, input bit rep);
    if_valid = 1'b1; if_tid = tid; if_tid_parity = (^tid) ^ bad_par; if_replay = rep; if_vpc = vpc;
    tick();
    if_valid = 1'b0; if_replay = 1'b0;
    r_hit = if_hit; r_miss = if_miss; r_perr = if_perr; r_data = if_data;
  endtask

  task automatic model_lookup(input string nm, input logic [TIDW-1:0] tid, input logic [29:0] vpc,
                              input bit rep, output bit missed);
    logic [IDXW-1:0] idx;
    bit exp_hit;
    idx = vpc[10:3];
    exp_hit = m_vld[idx] && (m_tag[idx] == vpc[29:11]);
    lookup(tid, vpc, 1'b0, rep);
    chk({nm, "_hit"}, r_hit, exp_hit);
    chk({nm, "_miss"}, r_miss, !exp_hit);
    chk({nm, "_perr"}, r_perr, 0);
    if (exp_hit) chk({nm, "_data"}, r_data, m_base[idx] + 32'(vpc[2:0]));
    missed = !exp_hit;
  endtask

  // Entered in the cycle the miss is visible; drives the memory side through a whole line refill.
  task automatic serve(input logic [29:0] vpc, input logic [TIDW-1:0] tid, input logic [31:0] base,
                       input int dly, input int gapmax, input bit inject, input bit probe);
    chk("req_lat1", mem_req_valid, 0);
    tick();
    chk("req_lat2", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, vpc >> 3);
    for (int k = 0; k < dly; k++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD0000 | k;   // stray beats must be ignored
      tick();
      mem_rsp_valid = 1'b0;
      chk("req_hold_v", mem_req_valid, 1);
      chk("req_hold_a", mem_req_addr, vpc >> 3);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("req_drop", mem_req_valid, 0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(gapmax, 0)) tick();
      if (inject && i == 3) begin
        lookup(6'd7, 30'h400, 1'b0, 1'b0);
        chk("busy_miss", r_miss, 1);
        chk("busy_hit", r_hit, 0);
        lookup(6'd2, vpc, 1'b0, 1'b0);
        chk("fillline_miss", r_miss, 1);
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = base + 32'(i);
      tick();
      mem_rsp_valid = 1'b0;
      if (i < 7) chk("done_early", refill_done, 0);
    end
    chk("done", refill_done, 1);
    chk("done_tid", refill_tid, tid);
    m_vld[vpc[10:3]] = 1'b1; m_tag[vpc[10:3]] = vpc[29:11]; m_base[vpc[10:3]] = base;
    if (probe) begin
      lookup(tid, vpc, 1'b0, 1'b0);
      chk("donecyc_miss", r_miss, 1);
    end else begin
      tick();
    end
    chk("done_pulse", refill_done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    bit missed;
    logic [29:0] v;
    logic [TAGW-1:0] tg;
    logic [IDXW-1:0] ix;
    rst = 1'b1; if_valid = 1'b0; if_tid = '0; if_tid_parity = 1'b0; if_replay = 1'b0; if_vpc = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    foreach (m_vld[i]) m_vld[i] = 1'b0;

    tick();
    chk("rst_hit", if_hit, 0);      chk("rst_miss", if_miss, 0);  chk("rst_perr", if_perr, 0);
    chk("rst_req", mem_req_valid, 0); chk("rst_done", refill_done, 0);
    chk("rst_tid", refill_tid, 0);  chk("rst_addr", mem_req_addr, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 255; i++) begin
      lookup(6'd0, 30'h0, 1'b0, 1'b0);
      chk("init_miss", r_miss, 1);
      chk("init_hit", r_hit, 0);
      chk("init_req", mem_req_valid, 0);
    end
    tick(); tick();
    chk("init_noreq", mem_req_valid, 0);

    tbl[0]  = '{6'd5,  30'h123,      1'b0, 32'h10000000, 5};
    tbl[1]  = '{6'd5,  30'h123,      1'b1, 32'h10000003, 0};
    tbl[2]  = '{6'd1,  30'h120,      1'b1, 32'h10000000, 0};
    tbl[3]  = '{6'd2,  30'h127,      1'b1, 32'h10000007, 0};
    tbl[4]  = '{6'd3,  30'h923,      1'b0, 32'h20000000, 0};
    tbl[5]  = '{6'd3,  30'h923,      1'b1, 32'h20000003, 0};
    tbl[6]  = '{6'd4,  30'h123,      1'b0, 32'h10000000, 2};
    tbl[7]  = '{6'd4,  30'h124,      1'b1, 32'h10000004, 0};
    tbl[8]  = '{6'd9,  30'h3FFFFFFF, 1'b0, 32'h30000000, 1};
    tbl[9]  = '{6'd9,  30'h3FFFFFFF, 1'b1, 32'h30000007, 0};
    tbl[10] = '{6'd63, 30'h3FFFFFF8, 1'b1, 32'h30000000, 0};
    for (int i = 0; i < 11; i++) begin
      lookup(tbl[i].tid, tbl[i].vpc, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_hit", i), r_hit, tbl[i].hit);
      chk($sformatf("tbl%0d_miss", i), r_miss, !tbl[i].hit);
      chk($sformatf("tbl%0d_perr", i), r_perr, 0);
      if (tbl[i].hit) chk($sformatf("tbl%0d_data", i), r_data, tbl[i].data);
      else serve(tbl[i].vpc, tbl[i].tid, tbl[i].data, tbl[i].dly, 1, 1'b0, 1'b0);
    end

    // Wrong tid parity on a resident line.
    lookup(6'd5, 30'h123, 1'b1, 1'b0);
`ifdef ICACHE_PARITY_EN
    chk("par_perr", r_perr, 1); chk("par_miss", r_miss, 1); chk("par_hit", r_hit, 0);
`else
    chk("par_perr", r_perr, 0); chk("par_miss", r_miss, 0); chk("par_hit", r_hit, 1);
`endif
    for (int k = 0; k < 3; k++) begin tick(); chk("par_noreq", mem_req_valid, 0); end

    // Miss while the engine is filling: reported, not captured, retried later.
    model_lookup("busy0", 6'd2, 30'h523, 1'b0, missed);
    serve(30'h523, 6'd2, 32'h40000000, 1, 1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin tick(); chk("busy_noreq", mem_req_valid, 0); end
    model_lookup("retry", 6'd7, 30'h400, 1'b1, missed);
    serve(30'h400, 6'd7, 32'h50000000, 0, 1, 1'b0, 1'b0);
    model_lookup("retry_hit", 6'd7, 30'h405, 1'b0, missed);
    chk("retry_resident", missed, 0);

    // Lookup registered in the install cycle sees the old (invalid) tag.
    model_lookup("dprobe0", 6'd11, 30'h5A8, 1'b0, missed);
    serve(30'h5A8, 6'd11, 32'h60000000, 0, 0, 1'b0, 1'b1);
    serve(30'h5A8, 6'd11, 32'h60000000, 0, 0, 1'b0, 1'b0);
    model_lookup("dprobe_hit", 6'd11, 30'h5AA, 1'b0, missed);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(3, 0))
        0: ix = 8'h24;
        1: ix = 8'h25;
        2: ix = 8'hA4;
        default: ix = 8'hFF;
      endcase
      case ($urandom_range(2, 0))
        0: tg = '0;
        1: tg = 19'd1;
        default: tg = '1;
      endcase
      v = {tg, ix, 3'($urandom_range(7, 0))};
      model_lookup("rnd", 6'($urandom_range(63, 0)), v, 1'($urandom_range(1, 0)), missed);
      if (missed) serve(v, if_tid, $urandom, $urandom_range(3, 0), 2, 1'b0, 1'b0);
    end

    // Reset in the middle of a fill: abort, resweep, ignore late beats.
    model_lookup("abort0", 6'd3, 30'h0ABC0, 1'b0, missed);
    tick();
    chk("abort_req", mem_req_valid, 1);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h70000000 + 32'(i); tick(); mem_rsp_valid = 1'b0;
    end
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    foreach (m_vld[i]) m_vld[i] = 1'b0;
    chk("abort_noreq", mem_req_valid, 0);
    chk("abort_addr", mem_req_addr, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0; tick(); mem_rsp_valid = 1'b0;
    chk("abort_nodone", refill_done, 0);
    repeat (258) tick();
    chk("abort_idle", mem_req_valid, 0);
    model_lookup("post_rst", 6'd5, 30'h123, 1'b0, missed);
    chk("post_rst_cold", missed, 1);
    serve(30'h123, 6'd5, 32'h80000000, 0, 1, 1'b0, 1'b0);
    model_lookup("post_rst_hit", 6'd5, 30'h126, 1'b0, missed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
